// File: rtl/bin2bcd_if.sv
// Handshake bundle between a producer/consumer (master) and the bin2bcd_seq converter (slave).
interface bin2bcd_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // the source holds its data and keeps valid asserted until that edge, and ready never waits on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, overflow, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, overflow, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, saturating on overflow.
// Optional macro BIN2BCD_LZ_BLANK_EN replaces leading-zero digits with the blank code 4'hF.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  bin2bcd_if.slave   bus,
  output logic [1:0] o_dbg_state
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]   r_acc;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [BW-1:0]   r_bcd;
  logic            r_ovf;

  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_shifted;
  logic            w_carry;
  logic            w_gt9;
  logic            w_ovf;
  logic [BW-1:0]   w_final;

  // One double-dabble step: correct each digit, then shift the next binary bit in.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
    w_shifted = {w_adj[BW-2:0], r_bin[WIDTH-1]};
    w_carry   = r_carry | w_adj[BW-1];
    w_gt9     = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shifted[4*d +: 4] > 4'd9)
        w_gt9 = 1'b1;
    end
    w_ovf = w_carry | w_gt9;
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic w_lead;
  always_comb begin
    w_final = w_shifted;
    w_lead  = 1'b1;
    if (w_ovf) begin
      for (int d = 0; d < DIGITS; d++) w_final[4*d +: 4] = 4'h9;
    end else begin
      // Blank from the top down until the first nonzero digit; ones digit always shown.
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (w_lead && (w_shifted[4*d +: 4] == 4'h0))
          w_final[4*d +: 4] = 4'hF;
        else
          w_lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    w_final = w_shifted;
    if (w_ovf) begin
      for (int d = 0; d < DIGITS; d++) w_final[4*d +: 4] = 4'h9;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_bin      <= bus.bin_in;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= CW'(WIDTH);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc   <= w_shifted;
          r_carry <= w_carry;
          r_bin   <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_bcd       <= w_final;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.bcd_out   = r_bcd;
  assign bus.overflow  = r_ovf;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 14-bit/4-digit main instance plus 8-bit/3-digit and 8-bit/2-digit.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [15:0] EXP_ZERO = 16'hFFF0;
  localparam logic [15:0] EXP_42   = 16'hFF42;
  localparam logic [11:0] EXP_7    = 12'hFF7;
  localparam logic [7:0]  EXP_5    = 8'hF5;
`else
  localparam logic [15:0] EXP_ZERO = 16'h0000;
  localparam logic [15:0] EXP_42   = 16'h0042;
  localparam logic [11:0] EXP_7    = 12'h007;
  localparam logic [7:0]  EXP_5    = 8'h05;
`endif

  bin2bcd_if #(.WIDTH(14), .DIGITS(4)) bus  ();
  bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) bus3 ();
  bin2bcd_if #(.WIDTH(8),  .DIGITS(2)) bus2 ();
  logic [1:0] dbg_state, dbg3, dbg2;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave),  .o_dbg_state(dbg_state));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave), .o_dbg_state(dbg3));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave), .o_dbg_state(dbg2));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard queues: {overflow, bcd_out}
  logic [16:0] exp_q[$];
  logic [12:0] exp_q3[$];
  logic [8:0]  exp_q2[$];
  logic [16:0] m_exp;
  logic [12:0] m_exp3;
  logic [8:0]  m_exp2;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result_w14d4", {15'd0, bus.overflow, bus.bcd_out}, 32'hFFFF_FFFF);
      else begin
        m_exp = exp_q.pop_front();
        check("result_w14d4", {15'd0, bus.overflow, bus.bcd_out}, {15'd0, m_exp});
      end
    end
    if (!rst && bus3.out_valid && bus3.out_ready) begin
      if (exp_q3.size() == 0) check("unexpected_result_w8d3", {19'd0, bus3.overflow, bus3.bcd_out}, 32'hFFFF_FFFF);
      else begin
        m_exp3 = exp_q3.pop_front();
        check("result_w8d3", {19'd0, bus3.overflow, bus3.bcd_out}, {19'd0, m_exp3});
      end
    end
    if (!rst && bus2.out_valid && bus2.out_ready) begin
      if (exp_q2.size() == 0) check("unexpected_result_w8d2", {23'd0, bus2.overflow, bus2.bcd_out}, 32'hFFFF_FFFF);
      else begin
        m_exp2 = exp_q2.pop_front();
        check("result_w8d2", {23'd0, bus2.overflow, bus2.bcd_out}, {23'd0, m_exp2});
      end
    end
  end

  // driver: waits for in_ready, pulses in_valid one cycle, then scrambles bin_in
  task automatic send(input logic [13:0] v, input logic push, input logic [16:0] exp);
    int n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stuck low, value=%0d", v);
      return;
    end
    bus.in_valid = 1'b1;
    bus.bin_in   = v;
    if (push) exp_q.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
    bus.bin_in   = 14'($urandom_range(0, 16383));
  endtask

  // returns cycles from acceptance edge until out_valid is visible
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
  endtask

  task automatic send_small3(input logic [7:0] v, input logic [12:0] exp);
    int n = 0;
    while (!bus3.in_ready && n < 100) begin tick(); n++; end
    bus3.in_valid = 1'b1; bus3.bin_in = v; exp_q3.push_back(exp);
    tick();
    bus3.in_valid = 1'b0;
    n = 0;
    while (!bus3.out_valid && n < 100) begin tick(); n++; end
    check("latency_w8d3", n, 8);
  endtask

  task automatic send_small2(input logic [7:0] v, input logic [8:0] exp);
    int n = 0;
    while (!bus2.in_ready && n < 100) begin tick(); n++; end
    bus2.in_valid = 1'b1; bus2.bin_in = v; exp_q2.push_back(exp);
    tick();
    bus2.in_valid = 1'b0;
    n = 0;
    while (!bus2.out_valid && n < 100) begin tick(); n++; end
    check("latency_w8d2", n, 8);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.bin_in = '0;  bus.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.bin_in = '0; bus3.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.bin_in = '0; bus2.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_in_ready",  bus.in_ready,  1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy",      bus.busy,      0);
    check("reset_bcd",       bus.bcd_out,   0);
    check("reset_overflow",  bus.overflow,  0);
    check("reset_state",     dbg_state,     0);

    // 1: basic conversion and latency
    send(14'd1234, 1'b1, {1'b0, 16'h1234});
    check("busy_in_shift", bus.busy, 1);
    check("in_ready_in_shift", bus.in_ready, 0);
    wait_valid(lat);
    check("latency_1234", lat, 14);

    // 2: boundaries back-to-back, plus a leading-zero case
    send(14'd0,    1'b1, {1'b0, EXP_ZERO});
    send(14'd9999, 1'b1, {1'b0, 16'h9999});
    send(14'd42,   1'b1, {1'b0, EXP_42});

    // 3: overflow saturation
    send(14'd10000, 1'b1, {1'b1, 16'h9999});
    send(14'd16383, 1'b1, {1'b1, 16'h9999});

    // 4: backpressure with an ignored in_valid pulse
    send(14'd4095, 1'b1, {1'b0, 16'h4095});
    bus.out_ready = 1'b0;
    wait_valid(lat);
    check("latency_4095", lat, 14);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.bin_in   = 14'd777;
      tick();
      check("held_bcd",      bus.bcd_out,   16'h4095);
      check("held_valid",    bus.out_valid, 1);
      check("held_in_ready", bus.in_ready,  0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready",  bus.in_ready,  1);
    repeat (20) tick();
    check("no_777_conversion", bus.out_valid, 0);

    // 5: reset mid-conversion, then fresh conversion
    send(14'd4321, 1'b0, '0);
    repeat (5) tick();
    check("busy_before_abort", bus.busy, 1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_state",     dbg_state,     0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_bcd",       bus.bcd_out,   0);
    check("abort_in_ready",  bus.in_ready,  1);
    send(14'd4321, 1'b1, {1'b0, 16'h4321});
    wait_valid(lat);
    check("latency_4321", lat, 14);

    // 6: other parameterisations
    send_small3(8'd255, {1'b0, 12'h255});
    send_small3(8'd7,   {1'b0, EXP_7});
    send_small2(8'd255, {1'b1, 8'h99});
    send_small2(8'd99,  {1'b0, 8'h99});
    send_small2(8'd100, {1'b1, 8'h99});
    send_small2(8'd5,   {1'b0, EXP_5});

    // drain
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && exp_q3.size() == 0 && exp_q2.size() == 0) break;
      tick();
    end
    check("drain_w14d4", exp_q.size(),  0);
    check("drain_w8d3",  exp_q3.size(), 0);
    check("drain_w8d2",  exp_q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
